ksa_engine: RTL and testbench

- Upstream neighbour of the RC4 keystream/decrypt compute stage.
- Owns the shared S-memory port during key setup. Runs the init pass S[i]=i, then the RC4 key-scheduling pass over the secret key.
- Emits a one-cycle done strobe when S holds the scheduled permutation, so the compute stage can be started.
- Contains its own FSM, i/j/key-index counters and a swap datapath.

---
 rtl/ksa_engine.sv | 171 +++++++++++++++++
 tb/tb_ksa_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key setup. Fills S[i]=i, then runs the key-scheduling
// pass over S through a single-port synchronous RAM and pulses done.
module ksa_engine #(
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned KEY_W  = 8 * KEY_BYTES;
    localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {
        IDLE,
        INIT_WR,
        KSA_RD_SI,
        KSA_STR_SI,
        KSA_RD_SJ,
        KSA_STR_SJ,
        KSA_WR_J,
        KSA_WR_I,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          i_q, i_d;
    logic [7:0]          j_q, j_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic [7:0]          s_i_q, s_i_d;
    logic [7:0]          s_j_q, s_j_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [7:0]          key_byte;

    logic [7:0]          addr_d;
    logic [7:0]          wrdata_d;
    logic                wren_d;
    logic                busy_d;
    logic                done_d;

    // Select the key byte addressed by kidx (byte 0 is the MSB of the key)
    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < int'(KEY_BYTES); k++) begin
            if (kidx_q == KIDX_W'(k)) begin
                key_byte = key_q[8*(int'(KEY_BYTES)-k)-1 -: 8];
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        s_i_d   = s_i_q;
        s_j_d   = s_j_q;
        key_d   = key_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = secret_key;
                    i_d     = 8'h00;
                    state_d = INIT_WR;
                end
            end
            INIT_WR: begin
                if (i_q == 8'hFF) begin
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    kidx_d  = '0;
                    state_d = KSA_RD_SI;
                end else begin
                    i_d = i_q + 8'h01;
                end
            end
            KSA_RD_SI: state_d = KSA_STR_SI;
            KSA_STR_SI: begin
                s_i_d   = s_rddata;
                j_d     = j_q + s_rddata + key_byte;
                state_d = KSA_RD_SJ;
            end
            KSA_RD_SJ: state_d = KSA_STR_SJ;
            KSA_STR_SJ: begin
                s_j_d   = s_rddata;
                state_d = KSA_WR_J;
            end
            KSA_WR_J: state_d = KSA_WR_I;
            KSA_WR_I: begin
                if (i_q == 8'hFF) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'h01;
                    kidx_d  = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
                    state_d = KSA_RD_SI;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from next state/registers
    always_comb begin
        addr_d   = 8'h00;
        wrdata_d = 8'h00;
        wren_d   = 1'b0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        case (state_d)
            INIT_WR: begin
                addr_d   = i_d;
                wrdata_d = i_d;
                wren_d   = 1'b1;
            end
            KSA_RD_SI, KSA_STR_SI: addr_d = i_d;
            KSA_RD_SJ, KSA_STR_SJ: addr_d = j_d;
            KSA_WR_J: begin
                addr_d   = j_d;
                wrdata_d = s_i_d;
                wren_d   = 1'b1;
            end
            KSA_WR_I: begin
                addr_d   = i_d;
                wrdata_d = s_j_d;
                wren_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= 8'h00;
            j_q      <= 8'h00;
            kidx_q   <= '0;
            s_i_q    <= 8'h00;
            s_j_q    <= 8'h00;
            key_q    <= '0;
            s_addr   <= 8'h00;
            s_wrdata <= 8'h00;
            s_wren   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            kidx_q   <= kidx_d;
            s_i_q    <= s_i_d;
            s_j_q    <= s_j_d;
            key_q    <= key_d;
            s_addr   <= addr_d;
            s_wrdata <= wrdata_d;
            s_wren   <= wren_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_ksa_engine.sv
// Directed bench for ksa_engine with a synchronous S-memory model.
module tb_ksa_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  s_rddata;
    logic [7:0]  s_addr;
    logic [7:0]  s_wrdata;
    logic        s_wren;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0_g = 0;

    logic [7:0] mem   [0:255];
    logic [7:0] exp_s [0:255];
    logic [15:0] wlog [$];
    int          wcyc [$];

    ksa_engine #(.KEY_BYTES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .secret_key (secret_key),
        .s_rddata   (s_rddata),
        .s_addr     (s_addr),
        .s_wrdata   (s_wrdata),
        .s_wren     (s_wren),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM
    always @(posedge clk) begin
        if (s_wren) mem[s_addr] <= s_wrdata;
        s_rddata <= mem[s_addr];
    end

    // Log every write with its cycle relative to the start edge
    always @(negedge clk) begin
        if (s_wren) begin
            wlog.push_back({s_addr, s_wrdata});
            wcyc.push_back(cyc - t0_g);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference RC4 key schedule
    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] j, t, kb;
        for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = key[23:16];
                1:       kb = key[15:8];
                default: kb = key[7:0];
            endcase
            j = j + exp_s[i] + kb;
            t = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic check_mem(input string tag, input logic [23:0] key);
        int bad = 0;
        ksa_model(key);
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_s[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    // mode 0: plain run; 1: extra start and key change mid-run; 2: async reset at cycle 900
    task automatic run_ksa(input logic [23:0] key, input int mode,
                           output logic got_done, output int dcyc);
        int rel;
        got_done = 1'b0;
        dcyc = -1;
        @(negedge clk);
        wlog.delete();
        wcyc.delete();
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0_g = cyc;
        for (int n = 0; n < 2100; n++) begin
            @(negedge clk);
            rel = cyc - t0_g;
            if (done) begin
                got_done = 1'b1;
                dcyc = rel;
                break;
            end
            if (mode == 1) begin
                if (rel == 499) start = 1'b1;
                if (rel == 500) start = 1'b0;
                if (rel == 599) secret_key = 24'hA5C33C;
            end
            if (mode == 2 && rel == 899) begin
                #3 rst_n = 1'b0;
                #1 check("rst_async_outs", {13'd0, s_addr, s_wrdata, s_wren, busy, done}, 32'd0);
            end
            if (mode == 2 && rel == 903) rst_n = 1'b1;
        end
    endtask

    logic gd;
    int   dc;
    int   bad;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        secret_key = 24'h123456;

        // Reset held with start asserted
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if ({s_addr, s_wrdata, s_wren, busy, done} !== 19'd0) bad++;
        end
        check("reset_outputs", 32'(bad), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {30'd0, busy, s_wren}, 32'd0);

        // Key 0: init pass and i==j swaps
        run_ksa(24'h000000, 0, gd, dc);
        check("k0_done", 32'(gd), 32'd1);
        check("k0_done_cycle", 32'(dc), 32'd1792);
        check("k0_busy_at_done", 32'(busy), 32'd1);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (wlog[i] !== {8'(i), 8'(i)}) bad++;
            if (wcyc[i] != i) bad++;
        end
        check("k0_init_writes", 32'(bad), 32'd0);
        check("k0_first_ksa_write_cycle", 32'(wcyc[256]), 32'd260);
        check("k0_it0_wrj", 32'(wlog[256]), 32'h0000);
        check("k0_it0_wri", 32'(wlog[257]), 32'h0000);
        check("k0_it1_wrj", 32'(wlog[258]), 32'h0101);
        check("k0_it1_wri", 32'(wlog[259]), 32'h0101);
        check("k0_it2_wrj", 32'(wlog[260]), 32'h0302);
        check("k0_it2_wri", 32'(wlog[261]), 32'h0203);
        check("k0_write_count", 32'(wlog.size()), 32'd768);
        @(negedge clk);
        check("k0_done_one_cycle", {30'd0, done, busy}, 32'd0);
        check_mem("k0_mem", 24'h000000);

        // Key 010203: key byte rotation
        run_ksa(24'h010203, 0, gd, dc);
        check("k1_done_cycle", 32'(dc), 32'd1792);
        check("k1_it0_wrj", 32'(wlog[256]), 32'h0100);
        check("k1_it0_wri", 32'(wlog[257]), 32'h0001);
        check("k1_it1_wrj", 32'(wlog[258]), 32'h0300);
        check("k1_it1_wri", 32'(wlog[259]), 32'h0103);
        check("k1_it2_wrj", 32'(wlog[260]), 32'h0802);
        check("k1_it3_wrj", 32'(wlog[262]), 32'h0900);
        check("k1_it3_wri", 32'(wlog[263]), 32'h0309);
        check_mem("k1_mem", 24'h010203);

        // Start and key changes while busy are ignored
        run_ksa(24'h010203, 1, gd, dc);
        check("dist_done_cycle", 32'(dc), 32'd1792);
        @(negedge clk);
        check("dist_done_one_cycle", 32'(done), 32'd0);
        check_mem("dist_mem", 24'h010203);

        // Second start from IDLE with another key
        run_ksa(24'h000000, 0, gd, dc);
        check("rerun_done_cycle", 32'(dc), 32'd1792);
        check_mem("rerun_mem", 24'h000000);

        // Async reset mid-KSA aborts without done
        run_ksa(24'h010203, 2, gd, dc);
        check("rst_no_done", 32'(gd), 32'd0);
        check("rst_idle", {30'd0, busy, s_wren}, 32'd0);

        run_ksa(24'h010203, 0, gd, dc);
        check("post_rst_done_cycle", 32'(dc), 32'd1792);
        check_mem("post_rst_mem", 24'h010203);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
